cd_return_demux_2x4: RTL
========================

Name: cd_return_demux_2x4

Overview:
- Return-path crossbar of the cardinal-router local side.
- Accepts up to two flits per cycle from the two convertor return channels and steers each to one of four local output ports, selected by a destination field in the flit.
- Each local output has a one-entry registered buffer and a per-output 2-way round-robin arbiter.
- Complements the 4x2 local-to-convertor crossbar, which drives the opposite direction.

Parameters:
- DATA_W, 64: flit width in bits.
- DEST_LSB, 8: LSB of the 2-bit destination field; dest = di[DEST_LSB+1:DEST_LSB], value 0..3 selects out port 0..3.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- cv_si  in  2  valid, one per convertor return channel.
- cv_ri  out  2  ready back to each convertor channel.
- cv_di  in  2*DATA_W  flits; channel k occupies [DATA_W*(k+1)-1 : DATA_W*k].
- out_so  out  4  valid, one per local output.
- out_ro  in  4  ready from each local consumer.
- out_do  out  4*DATA_W  flits; port j occupies [DATA_W*(j+1)-1 : DATA_W*j].

Behaviour:
- Transfer rule: a transfer occurs on a channel at a rising clk edge when its valid and ready are both 1.
- Per-output buffer: each output j holds full_j and data_j; out_so[j] = full_j and out_do[j] = data_j, both driven directly from registers.
- Output availability: avail_j = !full_j || out_ro[j], so a drain and a refill can happen in the same cycle.
- Request generation: req[k][j] = cv_si[k] && dest(cv_di[k]) == j.
- Arbitration: per output, a 2-requester round-robin arbiter with pointer ptr_j (0 = channel 0 favoured).
  - Single requester: that requester is granted.
  - Both requesting: channel ptr_j is granted.
  - Grants are issued only when avail_j = 1.
- Ready: cv_ri[k] = 1 iff channel k holds the grant at its destination output. cv_ri is combinational from cv_si, cv_di, out_ro and state. cv_ri[k] = 0 whenever cv_si[k] = 0.
- Pointer update: ptr_j toggles only when both channels request j and a grant is issued. It holds in all other cases, including a single requester, no request, or avail_j = 0.
- Accept path: on a granted transfer at edge t, data_j <= cv_di[k] and full_j <= 1. out_so[j] is visible in the cycle following edge t (latency 1 cycle).
- Drain: if out_so[j] && out_ro[j] && no grant this cycle, full_j <= 0. data_j holds its value.
- Stall: out_ro[j] = 0 with full_j = 1 leaves full_j/data_j unchanged, and no grant is issued to j.
- Concurrency and throughput:
  - Two channels with different destinations are both accepted in the same cycle.
  - Steady state with all out_ro = 1 gives one flit per output per cycle.
- Ordering: flits from one channel to one output are delivered in order; there is no drop and no duplication.
- Reset (reset = 0, asynchronous, including mid-transfer):
  - full_j = 0, data_j = 0, ptr_j = 0, hence out_so = 0 and out_do = 0.
  - cv_ri is forced to 0 while reset = 0.
  - Flits held in a buffer when reset asserts are discarded.
- Release: on reset release, the first accept can occur at the first rising edge at which reset = 1.

Decomposition:
- Package cd_pkg holds:
  - CD_DATA_W = 64, CD_DEST_LSB = 8, CD_N_CV = 2, CD_N_LOCAL = 4;
  - a dest-field extraction function.
- Sub-module cd_rr_arb2 holds the 2-requester round-robin arbiter: inputs req[1:0], en, clk, reset; outputs gnt[1:0]; owns ptr.
- cd_rr_arb2 is instantiated once per output (4 instances).
- Buffers and muxing stay in the top module.

Test Plan:
- Reset: hold reset = 0 with cv_si = 2'b11 -> cv_ri = 0, out_so = 0, out_do = 0. Assert reset mid-stream with a full buffer -> out_so goes to 0 immediately, with no clk edge needed.
- Disjoint routing: cv_di0 = {32'hF00DFACE,8'h00,8'd1,8'd5}, cv_di1 = {32'hF00DFACE,8'h00,8'd2,8'd7}, both valid, out_ro = 4'b1111 -> cv_ri = 2'b11. Next cycle out_so = 4'b0110, out_do port1 = ...0105, port2 = ...0207.
- Contention: both channels target dest 3 for 6 cycles, out_ro = 4'b1111 -> grants alternate ch0, ch1, ch0 … starting with ch0. out_do3 alternates sources each cycle. Exactly one cv_ri bit is high per cycle.
- Backpressure: out_ro[0] = 0 with ch0 streaming to dest 0 -> one flit accepted, then cv_ri[0] = 0 while the buffer is full. out_do0 holds the first flit. Raising out_ro[0] gives in-order resumption with no bubble.
- Drain+refill: out_ro[2] = 1 while full_2 = 1 and a new flit targets port 2 -> accepted in the same cycle. out_so[2] stays 1 and out_do2 updates to the new flit.
- Random: random cv_si/dest/out_ro for 200 cycles -> scoreboard per (channel, dest) shows every accepted flit appears exactly once, in order, 1 cycle minimum latency.

Source files
------------

// File: rtl/cd_pkg.sv
// Shared constants and flit helpers for the cardinal-router local-side
// return crossbar.
package cd_pkg;

  localparam int CD_DATA_W   = 64;
  localparam int CD_DEST_LSB = 8;
  localparam int CD_N_CV     = 2;
  localparam int CD_N_LOCAL  = 4;

  // Two-bit local destination carried inside the flit at bit position lsb.
  function automatic logic [1:0] cd_dest(input logic [CD_DATA_W-1:0] flit,
                                         input logic [5:0]           lsb);
    return flit[lsb +: 2];
  endfunction

endpackage

// File: rtl/cd_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer names the favoured channel
// and only moves when both channels compete and a grant is issued.
module cd_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11: begin
          gnt   = ptr_q ? 2'b10 : 2'b01;
          ptr_d = ~ptr_q;
        end
        default: gnt = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/cd_return_demux_2x4.sv
// Return-path crossbar: steers flits from two convertor channels into four
// one-entry registered local output buffers, arbitrated per output.
module cd_return_demux_2x4
  import cd_pkg::*;
#(
  parameter int DATA_W   = CD_DATA_W,
  parameter int DEST_LSB = CD_DEST_LSB
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CD_N_CV-1:0]           cv_si,
  output logic [CD_N_CV-1:0]           cv_ri,
  input  logic [CD_N_CV*DATA_W-1:0]    cv_di,
  output logic [CD_N_LOCAL-1:0]        out_so,
  input  logic [CD_N_LOCAL-1:0]        out_ro,
  output logic [CD_N_LOCAL*DATA_W-1:0] out_do
);

  logic [1:0]            dest   [CD_N_CV];
  logic [CD_N_CV-1:0]    req    [CD_N_LOCAL];
  logic [CD_N_CV-1:0]    gnt    [CD_N_LOCAL];
  logic [CD_N_LOCAL-1:0] avail;

  logic [CD_N_LOCAL-1:0] full_q;
  logic [CD_N_LOCAL-1:0] full_d;
  logic [DATA_W-1:0]     data_q [CD_N_LOCAL];
  logic [DATA_W-1:0]     data_d [CD_N_LOCAL];

  always_comb begin
    for (int k = 0; k < CD_N_CV; k++) begin
      dest[k] = cd_dest(CD_DATA_W'(cv_di[k*DATA_W +: DATA_W]), 6'(DEST_LSB));
    end
  end

  // A full buffer can still take a flit if it is being drained this cycle.
  always_comb begin
    for (int j = 0; j < CD_N_LOCAL; j++) begin
      avail[j] = !full_q[j] || out_ro[j];
      for (int k = 0; k < CD_N_CV; k++) begin
        req[j][k] = cv_si[k] && (dest[k] == 2'(j));
      end
    end
  end

  for (genvar j = 0; j < CD_N_LOCAL; j++) begin : g_arb
    cd_rr_arb2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (req[j]),
      .en    (avail[j]),
      .gnt   (gnt[j])
    );
  end

  // Each channel requests one output only, so OR-ing grants is exact.
  always_comb begin
    cv_ri = '0;
    for (int j = 0; j < CD_N_LOCAL; j++) begin
      cv_ri = cv_ri | gnt[j];
    end
    if (!reset) begin
      cv_ri = '0;
    end
  end

  always_comb begin
    full_d = full_q;
    for (int j = 0; j < CD_N_LOCAL; j++) begin
      data_d[j] = data_q[j];
      if (gnt[j][0]) begin
        full_d[j] = 1'b1;
        data_d[j] = cv_di[0 +: DATA_W];
      end else if (gnt[j][1]) begin
        full_d[j] = 1'b1;
        data_d[j] = cv_di[DATA_W +: DATA_W];
      end else if (full_q[j] && out_ro[j]) begin
        full_d[j] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q <= '0;
      for (int j = 0; j < CD_N_LOCAL; j++) begin
        data_q[j] <= '0;
      end
    end else begin
      full_q <= full_d;
      for (int j = 0; j < CD_N_LOCAL; j++) begin
        data_q[j] <= data_d[j];
      end
    end
  end

  assign out_so = full_q;

  for (genvar j = 0; j < CD_N_LOCAL; j++) begin : g_out
    assign out_do[j*DATA_W +: DATA_W] = data_q[j];
  end

endmodule
